// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for a 16x16 LED matrix: fetches a column word per row,
// shifts it out MSB first, latches it, then lights that row for DWELL cycles.
module dot_matrix_scanner #(
    parameter int DWELL = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] col_in,
    output logic [3:0]  row_bin,
    output logic [15:0] row_sel,
    output logic        ser_data,
    output logic        ser_clk,
    output logic        ser_latch,
    output logic        frame_done
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    state_t         state;
    logic [15:0]    shreg;
    logic [4:0]     bit_cnt;
    logic [DW-1:0]  dwell_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            dwell_cnt  <= '0;
            row_bin    <= '0;
            row_sel    <= 16'hFFFF;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    row_sel <= 16'hFFFF;
                    if (en)
                        state <= LOAD;
                end
                LOAD: begin
                    shreg    <= col_in;
                    bit_cnt  <= '0;
                    ser_data <= col_in[15];
                    ser_clk  <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    // bit_cnt[0] is the ser_clk phase; the bit advances after the high phase
                    if (bit_cnt == 5'd31) begin
                        ser_clk   <= 1'b0;
                        ser_data  <= 1'b0;
                        ser_latch <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        ser_clk <= ~bit_cnt[0];
                        if (bit_cnt[0]) begin
                            shreg    <= {shreg[14:0], 1'b0};
                            ser_data <= shreg[14];
                        end
                    end
                end
                LATCH: begin
                    ser_latch <= 1'b0;
                    row_sel   <= ~(16'h1 << row_bin);
                    dwell_cnt <= '0;
                    state     <= DISPLAY;
                end
                DISPLAY: begin
                    if (dwell_cnt == DW'(DWELL - 1)) begin
                        row_sel <= 16'hFFFF;
                        if (en) begin
                            row_bin    <= row_bin + 4'd1;
                            frame_done <= (row_bin == 4'hF);
                            state      <= LOAD;
                        end else begin
                            row_bin <= '0;
                            state   <= IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Bench for dot_matrix_scanner: row-period arithmetic model checked every
// cycle, plus directed scan scenarios and a randomized soak.
module tb_dot_matrix_scanner;

    localparam int DWELL = 4;
    localparam int PER   = 34 + DWELL;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] col_in;
    logic [3:0]  row_bin;
    logic [15:0] row_sel;
    logic        ser_data;
    logic        ser_clk;
    logic        ser_latch;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;

    logic        rnd_mode = 1'b0;
    logic        tog      = 1'b0;
    logic [15:0] rnd_word = 16'h0;

    // model: running flag, position inside the row period, row, captured word
    bit          m_run = 1'b0;
    int          m_p   = 0;
    int          m_r   = 0;
    logic [15:0] m_w   = 16'h0;
    bit          m_fd  = 1'b0;

    // observation records
    logic [15:0] cap [16];
    int          rises [16];
    int          disp_cnt [16];
    int          cyc = 0;
    int          last_rise = 0;
    int          latch_cyc = 0;
    int          fd_cnt = 0;
    int          fd_last = 0;
    int          fd_prev = 0;
    logic        prev_clk = 1'b0;
    int          n;
    int          fdc;

    dot_matrix_scanner #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .col_in     (col_in),
        .row_bin    (row_bin),
        .row_sel    (row_sel),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [3:0] r);
        case (r)
            4'd1:    return 16'h0FF0;
            4'd2:    return 16'h0010;
            4'd8:    return 16'h0800;
            default: return 16'h0000;
        endcase
    endfunction

    assign col_in = rnd_mode ? rnd_word :
                    (tog && m_run && m_p >= 1 && m_p <= 32) ? rnd_word :
                    rom(row_bin);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_p   <= 0;
            m_r   <= 0;
            m_fd  <= 1'b0;
        end else if (!m_run) begin
            m_fd <= 1'b0;
            m_p  <= 0;
            if (en)
                m_run <= 1'b1;
        end else begin
            m_fd <= 1'b0;
            if (m_p == 0)
                m_w <= col_in;
            if (m_p == PER - 1) begin
                m_p <= 0;
                if (en) begin
                    m_fd <= (m_r == 15);
                    m_r  <= (m_r + 1) % 16;
                end else begin
                    m_run <= 1'b0;
                    m_r   <= 0;
                end
            end else begin
                m_p <= m_p + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e_sel;
        logic        e_clk;
        logic        e_dat;
        logic        e_lat;
        logic        shifting;
        shifting = m_run && m_p >= 1 && m_p <= 32;
        e_sel = (m_run && m_p >= 34) ? ~(16'h1 << m_r) : 16'hFFFF;
        e_clk = shifting && ((m_p - 1) % 2 == 1);
        e_dat = shifting ? m_w[15 - (m_p - 1) / 2] : 1'b0;
        e_lat = m_run && m_p == 33;
        vectors++;
        if (row_sel !== e_sel || row_bin !== 4'(m_r) || ser_clk !== e_clk ||
            ser_data !== e_dat || ser_latch !== e_lat || frame_done !== m_fd) begin
            errors++;
            $display("FAIL model cyc=%0d got sel=%h bin=%h d=%b c=%b l=%b fd=%b exp sel=%h bin=%h d=%b c=%b l=%b fd=%b",
                     cyc, row_sel, row_bin, ser_data, ser_clk, ser_latch, frame_done,
                     e_sel, 4'(m_r), e_dat, e_clk, e_lat, m_fd);
        end
        if (ser_clk && !prev_clk) begin
            cap[row_bin]   = {cap[row_bin][14:0], ser_data};
            rises[row_bin] = rises[row_bin] + 1;
            last_rise      = cyc;
        end
        prev_clk = ser_clk;
        if (ser_latch)
            latch_cyc = cyc;
        for (int i = 0; i < 16; i++)
            if (row_sel == ~(16'h1 << i))
                disp_cnt[i] = disp_cnt[i] + 1;
        if (frame_done) begin
            fd_cnt++;
            fd_prev = fd_last;
            fd_last = cyc;
        end
        cyc++;
    end

    task automatic step();
        @(negedge clk);
        #1;
        rnd_word = 16'($urandom);
    endtask

    task automatic clear();
        for (int i = 0; i < 16; i++) begin
            cap[i]      = 16'h0;
            rises[i]    = 0;
            disp_cnt[i] = 0;
        end
        fd_cnt = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        vectors++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    function automatic int sum_rises();
        int s = 0;
        for (int i = 0; i < 16; i++)
            s += rises[i];
        return s;
    endfunction

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clear();
        repeat (3) step();
        rst_n = 1'b1;
        clear();
        repeat (20) step();
        check("idle_rises", sum_rises(), 0);
        check("idle_sel", row_sel, 16'hFFFF);
        check("idle_bin", row_bin, 0);

        // rows 0 and 1 from reset
        clear();
        en = 1'b1;
        n = 0;
        while (row_bin != 4'd2 && n < 300) begin step(); n++; end
        if (n >= 300) expire("rows01");
        check("row0_word", cap[0], 16'h0000);
        check("row0_rises", rises[0], 16);
        check("row1_word", cap[1], 16'h0FF0);
        check("row1_rises", rises[1], 16);
        check("row1_dwell", disp_cnt[1], DWELL);
        check("row1_latch_gap", latch_cyc - last_rise, 1);

        // full frame with en held
        n = 0;
        while (fd_cnt < 2 && n < 1500) begin step(); n++; end
        if (n >= 1500) expire("frame");
        check("frame_period", fd_last - fd_prev, 16 * PER);
        check("row8_word", cap[8], 16'h0800);

        // drop en during SHIFT of row 5
        n = 0;
        while (!(row_bin == 4'd5 && ser_clk) && n < 700) begin step(); n++; end
        if (n >= 700) expire("row5");
        en = 1'b0;
        clear();
        fdc = fd_cnt;
        repeat (60) step();
        check("row5_dwell", disp_cnt[5], DWELL);
        check("stop_bin", row_bin, 0);
        check("stop_sel", row_sel, 16'hFFFF);
        check("stop_fd", fd_cnt, fdc);

        // reset during DISPLAY of row 3
        en = 1'b1;
        n = 0;
        while (row_sel != 16'hFFF7 && n < 300) begin step(); n++; end
        if (n >= 300) expire("row3");
        rst_n = 1'b0;
        step();
        check("rst_sel", row_sel, 16'hFFFF);
        check("rst_bin", row_bin, 0);
        check("rst_ser", {ser_data, ser_clk, ser_latch}, 3'b000);
        rst_n = 1'b1;
        n = 0;
        while (row_sel == 16'hFFFF && n < 100) begin step(); n++; end
        if (n >= 100) expire("restart");
        check("restart_row", row_sel, 16'hFFFE);

        // col_in churns during SHIFT; captured word must be the LOAD-cycle value
        tog = 1'b1;
        cap[2]   = 16'h0;
        rises[2] = 0;
        n = 0;
        while (row_bin != 4'd3 && n < 200) begin step(); n++; end
        if (n >= 200) expire("row2");
        check("row2_word", cap[2], 16'h0010);
        check("row2_rises", rises[2], 16);
        tog = 1'b0;

        // randomized soak
        rnd_mode = 1'b1;
        repeat (4000) begin
            step();
            if ($urandom_range(0, 199) == 0)
                en = ~en;
            rst_n = ($urandom_range(0, 1999) != 0);
        end
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
